// File: rtl/async_fifo_pkg.sv
// Shared helpers for the FIFO: pointer sizing and parameter legality.
package async_fifo_pkg;

   // One extra pointer bit distinguishes full from empty when the low bits match.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit depth_is_legal(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// Storage array: synchronous write, asynchronous read, contents never reset.
module fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) mem_q[i_waddr] <= i_wdata;
   end

   assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO with wrap-bit pointers; read port is registered or
// first-word-fall-through depending on FWFT.
module async_fifo
   import async_fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int FWFT  = 0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_wen,
   output logic             o_full,
   output logic [WIDTH-1:0] o_rdata,
   input  logic             i_ren,
   output logic             o_empty
);

   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;

   if (!depth_is_legal(DEPTH)) begin : g_bad_depth
      $error("async_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic             wr_acc, rd_acc;
   logic [WIDTH-1:0] mem_rdata;

   // Flags come from the pointer registers alone, never from the requests.
   assign o_empty = (wptr_q == rptr_q);
   assign o_full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

   always_comb begin
      wr_acc = i_wen && !o_full;
      rd_acc = i_ren && !o_empty;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (wr_acc) wptr_d = wptr_q + PW'(1);
      if (rd_acc) rptr_d = rptr_q + PW'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (wr_acc),
      .i_waddr (wptr_q[AW-1:0]),
      .i_wdata (i_wdata),
      .i_raddr (rptr_q[AW-1:0]),
      .o_rdata (mem_rdata)
   );

   if (FWFT != 0) begin : g_fwft
      assign o_rdata = mem_rdata;
   end else begin : g_std
      logic [WIDTH-1:0] rdata_q, rdata_d;

      always_comb begin
         rdata_d = rdata_q;
         if (rd_acc) rdata_d = mem_rdata;
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) rdata_q <= '0;
         else          rdata_q <= rdata_d;
      end

      assign o_rdata = rdata_q;
   end

endmodule

// File: tb/tb_async_fifo.sv
// Directed and model-checked bench driving a standard and an FWFT FIFO in lockstep.
module tb_async_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] wdata;
   logic       wen, ren;
   logic       full0, empty0, full1, empty1;
   logic [7:0] rdata0, rdata1;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] q[$];
   logic [7:0] exp_v;

   always #5 clk = ~clk;

   async_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(0)) dut_std (
      .i_clk(clk), .i_rst_n(rst_n), .i_wdata(wdata), .i_wen(wen),
      .o_full(full0), .o_rdata(rdata0), .i_ren(ren), .o_empty(empty0)
   );

   async_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(1)) dut_fwft (
      .i_clk(clk), .i_rst_n(rst_n), .i_wdata(wdata), .i_wen(wen),
      .o_full(full1), .o_rdata(rdata1), .i_ren(ren), .o_empty(empty1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wen = 1'b0; ren = 1'b0; wdata = 8'h00;
      tick(); tick();
      n_cmp++; if (empty0 !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty0); end
      n_cmp++; if (full0 !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full0); end
      n_cmp++; if (rdata0 !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h want 00", rdata0); end
      n_cmp++; if (empty1 !== 1'b1) begin n_err++; $display("FAIL reset_empty_fwft: got %b want 1", empty1); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 16; i++) begin
         wdata = 8'(i); wen = 1'b1;
         tick();
         if (i == 1) begin
            n_cmp++; if (empty0 !== 1'b0) begin n_err++; $display("FAIL fill_empty_fall: got %b want 0", empty0); end
            n_cmp++; if (rdata1 !== 8'd1) begin n_err++; $display("FAIL fill_fwft_head: got %h want 01", rdata1); end
         end
         n_cmp++; if (full0 !== (i == 16)) begin n_err++; $display("FAIL fill_full[%0d]: got %b want %b", i, full0, (i == 16)); end
      end
      wdata = 8'd17;
      tick();
      wen = 1'b0;
      n_cmp++; if (full0 !== 1'b1) begin n_err++; $display("FAIL fill_17_full: got %b want 1", full0); end
      n_cmp++; if (rdata1 !== 8'd1) begin n_err++; $display("FAIL fill_17_head: got %h want 01", rdata1); end
   endtask

   task automatic test_drain();
      n_cmp++; if (rdata0 !== 8'h00) begin n_err++; $display("FAIL drain_pre: got %h want 00", rdata0); end
      for (int i = 1; i <= 16; i++) begin
         n_cmp++; if (rdata1 !== 8'(i)) begin n_err++; $display("FAIL drain_fwft_head[%0d]: got %h want %h", i, rdata1, 8'(i)); end
         ren = 1'b1;
         tick();
         n_cmp++; if (rdata0 !== 8'(i)) begin n_err++; $display("FAIL drain_rdata[%0d]: got %h want %h", i, rdata0, 8'(i)); end
         n_cmp++; if (full0 !== 1'b0) begin n_err++; $display("FAIL drain_full[%0d]: got %b want 0", i, full0); end
         n_cmp++; if (empty0 !== (i == 16)) begin n_err++; $display("FAIL drain_empty[%0d]: got %b want %b", i, empty0, (i == 16)); end
      end
      tick(); tick();
      ren = 1'b0;
      n_cmp++; if (rdata0 !== 8'd16) begin n_err++; $display("FAIL drain_hold: got %h want 10", rdata0); end
      n_cmp++; if (empty0 !== 1'b1) begin n_err++; $display("FAIL drain_hold_empty: got %b want 1", empty0); end
   endtask

   task automatic test_fwft();
      wdata = 8'hA5; wen = 1'b1;
      tick();
      wen = 1'b0;
      n_cmp++; if (rdata1 !== 8'hA5) begin n_err++; $display("FAIL fwft_show: got %h want a5", rdata1); end
      n_cmp++; if (empty1 !== 1'b0) begin n_err++; $display("FAIL fwft_empty: got %b want 0", empty1); end
      n_cmp++; if (rdata0 !== 8'd16) begin n_err++; $display("FAIL fwft_std_hold: got %h want 10", rdata0); end
      ren = 1'b1;
      tick();
      ren = 1'b0;
      n_cmp++; if (empty1 !== 1'b1) begin n_err++; $display("FAIL fwft_pop_empty: got %b want 1", empty1); end
      n_cmp++; if (rdata0 !== 8'hA5) begin n_err++; $display("FAIL fwft_std_rdata: got %h want a5", rdata0); end
   endtask

   task automatic test_simultaneous();
      q.delete();
      for (int i = 0; i < 8; i++) begin
         wdata = 8'(8'h10 + i); wen = 1'b1; q.push_back(wdata);
         tick();
      end
      for (int k = 0; k < 40; k++) begin
         wdata = 8'(8'h40 + k); wen = 1'b1; ren = 1'b1;
         exp_v = q.pop_front(); q.push_back(wdata);
         n_cmp++; if (rdata1 !== exp_v) begin n_err++; $display("FAIL sim_fwft_head[%0d]: got %h want %h", k, rdata1, exp_v); end
         tick();
         n_cmp++; if (rdata0 !== exp_v) begin n_err++; $display("FAIL sim_rdata[%0d]: got %h want %h", k, rdata0, exp_v); end
         n_cmp++; if ({full0, empty0} !== 2'b00) begin n_err++; $display("FAIL sim_flags[%0d]: got %b want 00", k, {full0, empty0}); end
      end
      wen = 1'b0;
      while (q.size() > 0) begin
         exp_v = q.pop_front(); ren = 1'b1;
         tick();
         n_cmp++; if (rdata0 !== exp_v) begin n_err++; $display("FAIL sim_drain: got %h want %h", rdata0, exp_v); end
      end
      ren = 1'b0;
      n_cmp++; if (empty0 !== 1'b1) begin n_err++; $display("FAIL sim_drain_empty: got %b want 1", empty0); end

      for (int i = 0; i < 16; i++) begin
         wdata = 8'(8'h80 + i); wen = 1'b1; q.push_back(wdata);
         tick();
      end
      n_cmp++; if (full0 !== 1'b1) begin n_err++; $display("FAIL full_both_pre: got %b want 1", full0); end
      wdata = 8'hEE; wen = 1'b1; ren = 1'b1;
      exp_v = q.pop_front();
      tick();
      wen = 1'b0;
      n_cmp++; if (full0 !== 1'b0) begin n_err++; $display("FAIL full_both_full: got %b want 0", full0); end
      n_cmp++; if (rdata0 !== exp_v) begin n_err++; $display("FAIL full_both_rdata: got %h want %h", rdata0, exp_v); end
      while (q.size() > 0) begin
         exp_v = q.pop_front();
         tick();
         n_cmp++; if (rdata0 !== exp_v) begin n_err++; $display("FAIL full_both_drain: got %h want %h", rdata0, exp_v); end
      end
      ren = 1'b0;
      n_cmp++; if (empty0 !== 1'b1) begin n_err++; $display("FAIL full_both_dropped: got empty %b want 1", empty0); end

      wdata = 8'h77; wen = 1'b1; ren = 1'b1;
      tick();
      wen = 1'b0; ren = 1'b0;
      n_cmp++; if (empty0 !== 1'b0) begin n_err++; $display("FAIL empty_both_empty: got %b want 0", empty0); end
      n_cmp++; if (rdata0 !== 8'h8F) begin n_err++; $display("FAIL empty_both_hold: got %h want 8f", rdata0); end
      n_cmp++; if (rdata1 !== 8'h77) begin n_err++; $display("FAIL empty_both_fwft: got %h want 77", rdata1); end
      ren = 1'b1;
      tick();
      ren = 1'b0;
      n_cmp++; if (rdata0 !== 8'h77) begin n_err++; $display("FAIL empty_both_read: got %h want 77", rdata0); end
      n_cmp++; if (empty0 !== 1'b1) begin n_err++; $display("FAIL empty_both_final: got %b want 1", empty0); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         wdata = 8'(8'hC0 + i); wen = 1'b1;
         tick();
      end
      wen = 1'b0;
      n_cmp++; if (empty0 !== 1'b0) begin n_err++; $display("FAIL rstmid_pre: got %b want 0", empty0); end
      rst_n = 1'b0;
      #2;
      n_cmp++; if (empty0 !== 1'b1) begin n_err++; $display("FAIL rstmid_empty: got %b want 1", empty0); end
      n_cmp++; if (empty1 !== 1'b1) begin n_err++; $display("FAIL rstmid_empty_fwft: got %b want 1", empty1); end
      n_cmp++; if (rdata0 !== 8'h00) begin n_err++; $display("FAIL rstmid_rdata: got %h want 00", rdata0); end
      tick();
      rst_n = 1'b1;
      ren = 1'b1;
      tick();
      ren = 1'b0;
      n_cmp++; if ({empty0, rdata0} !== 9'h100) begin n_err++; $display("FAIL rstmid_after: got %b/%h want 1/00", empty0, rdata0); end
   endtask

   task automatic test_random();
      logic [7:0] last_rd;
      bit wa, ra;
      q.delete();
      last_rd = 8'h00;
      for (int c = 0; c < 10000; c++) begin
         wen = ($urandom_range(0, 99) < (((c / 200) % 2) != 0 ? 30 : 70));
         ren = ($urandom_range(0, 99) < (((c / 200) % 2) != 0 ? 70 : 30));
         wdata = 8'($urandom);
         n_cmp++; if (empty0 !== (q.size() == 0)) begin n_err++; $display("FAIL rnd_empty[%0d]: got %b want %b", c, empty0, (q.size() == 0)); end
         n_cmp++; if (full0 !== (q.size() == 16)) begin n_err++; $display("FAIL rnd_full[%0d]: got %b want %b", c, full0, (q.size() == 16)); end
         n_cmp++; if ({full1, empty1} !== {full0, empty0}) begin n_err++; $display("FAIL rnd_flags_fwft[%0d]: got %b want %b", c, {full1, empty1}, {full0, empty0}); end
         if (q.size() > 0) begin
            n_cmp++; if (rdata1 !== q[0]) begin n_err++; $display("FAIL rnd_fwft_head[%0d]: got %h want %h", c, rdata1, q[0]); end
         end
         wa = wen && (q.size() < 16);
         ra = ren && (q.size() > 0);
         if (ra) last_rd = q.pop_front();
         if (wa) q.push_back(wdata);
         tick();
         n_cmp++; if (rdata0 !== last_rd) begin n_err++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, rdata0, last_rd); end
      end
      wen = 1'b0; ren = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_fwft();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
